simon_seq_player: RTL and testbench

//  Game sequencer for Simon Says; it is the initiator of the game number memory (address/rw/in_num/out_num).

---
 rtl/simon_seq_player_pkg.sv | 23 ++
 rtl/simon_seq_player_if.sv | 25 ++
 rtl/simon_seq_player_lfsr.sv | 23 ++
 rtl/simon_seq_player.sv | 205 ++++++++++++++++++++
 tb/tb_simon_seq_player.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_seq_player_pkg.sv
// Simon Says sequencer: shared widths, number type and FSM states.
// Package simon_pkg; imported by the interface, LFSR and top.
package simon_pkg;

  localparam int NUM_W     = 2;
  localparam int ADDR_W    = 4;
  localparam int MEM_DEPTH = 16;

  typedef logic [NUM_W-1:0] num_t;

  typedef enum logic [3:0] {
    IDLE,
    APPEND,
    PLAY_RD,
    PLAY_CAP,
    SHOW_ON,
    SHOW_OFF,
    USER_RD,
    USER_CAP,
    USER_WAIT
  } state_e;

endpackage

// File: rtl/simon_seq_player_if.sv
// Game number memory bus: the sequencer is master, memory is slave.
// Read data is registered and valid the cycle after the address.
interface simon_seq_player_if;
  import simon_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              rw;
  num_t              in_num;
  num_t              out_num;

  modport master (
    output address,
    output rw,
    output in_num,
    input  out_num
  );

  modport slave (
    input  address,
    input  rw,
    input  in_num,
    output out_num
  );

endinterface

// File: rtl/simon_seq_player_lfsr.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4, free-running.
// A zero seed would lock up, so it is replaced by 8'h01.
module simon_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic [7:0] state
);

  localparam logic [7:0] INIT =
    (SEED == 8'h00) ? 8'h01 : SEED;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
    end else begin
      state <= {state[6:0],
                state[7] ^ state[5] ^ state[4] ^ state[3]};
    end
  end

endmodule

// File: rtl/simon_seq_player.sv
// Simon Says game sequencer: append, play back, check presses.
// Optional press timeout enabled by defining SIMON_TIMEOUT_EN.
module simon_seq_player
  import simon_pkg::*;
#(
  parameter int          MAX_LEN    = 11,
  parameter logic [15:0] ON_CYCLES  = 16'd50,
  parameter logic [15:0] OFF_CYCLES = 16'd25,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
`ifdef SIMON_TIMEOUT_EN
  ,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
`endif
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                btn_valid,
  input  num_t                btn_num,
  output logic                btn_ready,
  output logic                led_valid,
  output num_t                led_num,
  output logic                busy,
  output logic [3:0]          round_len,
  output logic                win,
  output logic                lose,
  simon_seq_player_if.master  mem
);

  state_e      state_q, state_d;
  logic [4:0]  len_q;
  logic [4:0]  idx_q;
  logic [15:0] cnt_q;
  num_t        led_q;
  num_t        exp_q;
  logic        win_q, lose_q;
  logic        win_d, lose_d;
  logic [7:0]  lfsr;
  logic        unused_lfsr;

  logic [4:0]  idx_inc;
  logic        last;
  logic        hit;
  logic        on_done;
  logic        off_done;
  logic        to_done;

  simon_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .state   (lfsr)
  );

  assign unused_lfsr = ^lfsr[7:2];

  assign idx_inc  = idx_q + 5'd1;
  assign last     = (idx_inc == len_q);
  assign hit      = (btn_num == exp_q);
  assign on_done  = (cnt_q == ON_CYCLES - 16'd1);
  assign off_done = (cnt_q == OFF_CYCLES - 16'd1);

`ifdef SIMON_TIMEOUT_EN
  logic [15:0] timer_q;
  assign to_done = (timer_q == TIMEOUT_CYCLES - 16'd1);
`else
  assign to_done = 1'b0;
`endif

  assign btn_ready = (state_q == USER_WAIT);
  assign led_valid = (state_q == SHOW_ON);
  assign busy      = (state_q != IDLE);
  assign led_num   = led_q;
  assign round_len = len_q[3:0];
  assign win       = win_q;
  assign lose      = lose_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    win_d       = 1'b0;
    lose_d      = 1'b0;
    mem.address = '0;
    mem.rw      = 1'b0;
    mem.in_num  = '0;
    unique case (state_q)
      IDLE: ;
      APPEND: begin
        mem.address = len_q[3:0];
        mem.rw      = 1'b1;
        mem.in_num  = lfsr[1:0];
        state_d     = PLAY_RD;
      end
      PLAY_RD: begin
        mem.address = idx_q[3:0];
        state_d     = PLAY_CAP;
      end
      PLAY_CAP: state_d = SHOW_ON;
      SHOW_ON: begin
        if (on_done) state_d = SHOW_OFF;
      end
      SHOW_OFF: begin
        if (off_done)
          state_d = last ? USER_RD : PLAY_RD;
      end
      USER_RD: begin
        mem.address = idx_q[3:0];
        state_d     = USER_CAP;
      end
      USER_CAP: state_d = USER_WAIT;
      USER_WAIT: begin
        if (btn_valid) begin
          if (!hit) begin
            lose_d  = 1'b1;
            state_d = IDLE;
          end else if (!last) begin
            state_d = USER_RD;
          end else if (len_q == 5'(MAX_LEN)) begin
            win_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = APPEND;
          end
        end else if (to_done) begin
          lose_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // a restart abandons the game silently, even over a press
    if (start) begin
      state_d = APPEND;
      win_d   = 1'b0;
      lose_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_q  <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      led_q  <= '0;
      exp_q  <= '0;
      win_q  <= 1'b0;
      lose_q <= 1'b0;
    end else begin
      win_q  <= win_d;
      lose_q <= lose_d;
      if (start) begin
        len_q <= '0;
        idx_q <= '0;
        cnt_q <= '0;
      end else begin
        unique case (state_q)
          APPEND: begin
            len_q <= len_q + 5'd1;
            idx_q <= '0;
          end
          PLAY_CAP: begin
            led_q <= mem.out_num;
            cnt_q <= '0;
          end
          SHOW_ON: begin
            cnt_q <= on_done ? 16'd0 : cnt_q + 16'd1;
          end
          SHOW_OFF: begin
            if (off_done) begin
              cnt_q <= '0;
              idx_q <= last ? 5'd0 : idx_inc;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          USER_CAP: exp_q <= mem.out_num;
          USER_WAIT: begin
            if (btn_valid && hit)
              idx_q <= last ? 5'd0 : idx_inc;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SIMON_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
    end else if (state_q == USER_CAP) begin
      timer_q <= '0;
    end else if (state_q == USER_WAIT) begin
      timer_q <= timer_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_simon_seq_player.sv
// Directed bench for simon_seq_player with a 1-cycle registered memory.
// Define SIMON_TIMEOUT_EN to also exercise the press timeout.
module tb_simon_seq_player;
  import simon_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic btn_valid = 1'b0;
  num_t btn_num = '0;
  logic btn_ready, led_valid, busy, win, lose;
  num_t led_num;
  logic [3:0] round_len;

  int total = 0;
  int bad = 0;

  simon_seq_player_if mif ();

  simon_seq_player #(
    .MAX_LEN        (11),
    .ON_CYCLES      (16'd3),
    .OFF_CYCLES     (16'd2),
    .LFSR_SEED      (8'hA5)
`ifdef SIMON_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (16'd10)
`endif
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .btn_valid (btn_valid),
    .btn_num   (btn_num),
    .btn_ready (btn_ready),
    .led_valid (led_valid),
    .led_num   (led_num),
    .busy      (busy),
    .round_len (round_len),
    .win       (win),
    .lose      (lose),
    .mem       (mif.master)
  );

  always #5 clock = ~clock;

  num_t mem_arr [MEM_DEPTH];
  initial for (int i = 0; i < MEM_DEPTH; i++) mem_arr[i] = '0;

  always @(posedge clock) begin
    if (mif.rw) mem_arr[mif.address] <= mif.in_num;
    else        mif.out_num <= mem_arr[mif.address];
  end

  // reference LFSR: x^8+x^6+x^5+x^4, seed A5
  logic [7:0] mlfsr;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) mlfsr <= 8'hA5;
    else mlfsr <= {mlfsr[6:0],
                   mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
  end

  num_t seq [MEM_DEPTH];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && mif.rw) begin
      seq[mif.address] = mlfsr[1:0];
      check("wdata", 32'(mif.in_num), 32'(mlfsr[1:0]));
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!btn_ready && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (!btn_ready) check("ready_to", 32'(btn_ready), 32'd1);
  endtask

  task automatic press(input num_t n);
    wait_ready();
    btn_valid = 1'b1;
    btn_num   = n;
    @(negedge clock);
    btn_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic play_check(input int n);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      int hc = 0;
      while (!led_valid && t < 50) begin
        @(negedge clock);
        t++;
      end
      check("led_num", 32'(led_num), 32'(seq[k]));
      while (led_valid && hc < 20) begin
        hc++;
        @(negedge clock);
      end
      check("on_len", 32'(hc), 32'd3);
    end
  endtask

  task automatic play_round(input int r);
    play_check(r);
    wait_ready();
    check("round_len", 32'(round_len), 32'(r));
    for (int k = 0; k < r; k++) press(seq[k]);
  endtask

  initial begin
    int lat;
    int hc;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_len", 32'(round_len), 32'd0);
    check("rst_led", 32'(led_valid), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_rw", 32'(mif.rw), 32'd0);
    check("idle_addr", 32'(mif.address), 32'd0);

    // reset in the middle of SHOW_ON
    do_start();
    lat = 0;
    while (!led_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    @(negedge clock);
    check("pre_rst_led", 32'(led_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_led", 32'(led_valid), 32'd0);
    check("arst_num", 32'(led_num), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_len", 32'(round_len), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_len", 32'(round_len), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    // first round: append at 0, latency and LED length
    do_start();
    check("app_rw", 32'(mif.rw), 32'd1);
    check("app_addr", 32'(mif.address), 32'd0);
    check("app_len", 32'(round_len), 32'd0);
    lat = 1;
    while (!led_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    check("led0", 32'(led_num), 32'(seq[0]));
    hc = 0;
    while (led_valid && hc < 20) begin
      hc++;
      @(negedge clock);
    end
    check("on0", 32'(hc), 32'd3);
    wait_ready();
    check("ready", 32'(btn_ready), 32'd1);
    check("len1", 32'(round_len), 32'd1);
    press(seq[0]);

    // full game to a win
    for (int r = 2; r <= 11; r++) play_round(r);
    check("win", 32'(win), 32'd1);
    check("win_busy", 32'(busy), 32'd0);
    check("win_len", 32'(round_len), 32'd11);
    check("win_lose", 32'(lose), 32'd0);
    @(negedge clock);
    check("win_pulse", 32'(win), 32'd0);
    check("win_hold", 32'(round_len), 32'd11);

    // wrong second press in round 3
    do_start();
    play_round(1);
    play_round(2);
    play_check(3);
    press(seq[0]);
    press(seq[1] + 2'd1);
    check("lose", 32'(lose), 32'd1);
    check("lose_busy", 32'(busy), 32'd0);
    check("lose_len", 32'(round_len), 32'd3);
    check("lose_win", 32'(win), 32'd0);
    @(negedge clock);
    check("lose_pulse", 32'(lose), 32'd0);

    // start beats a press in USER_WAIT of round 2
    do_start();
    play_round(1);
    play_check(2);
    wait_ready();
    start     = 1'b1;
    btn_valid = 1'b1;
    btn_num   = seq[0];
    @(negedge clock);
    start     = 1'b0;
    btn_valid = 1'b0;
    check("rs_rw", 32'(mif.rw), 32'd1);
    check("rs_addr", 32'(mif.address), 32'd0);
    check("rs_len", 32'(round_len), 32'd0);
    check("rs_lose", 32'(lose), 32'd0);

`ifdef SIMON_TIMEOUT_EN
    play_check(1);
    wait_ready();
    for (int i = 2; i <= 10; i++) begin
      @(negedge clock);
      check("to_wait", 32'(btn_ready), 32'd1);
    end
    @(negedge clock);
    check("to_lose", 32'(lose), 32'd1);
    check("to_busy", 32'(busy), 32'd0);

    do_start();
    play_check(1);
    wait_ready();
    repeat (9) @(negedge clock);
    check("tie_ready", 32'(btn_ready), 32'd1);
    btn_valid = 1'b1;
    btn_num   = seq[0];
    @(negedge clock);
    btn_valid = 1'b0;
    check("tie_lose", 32'(lose), 32'd0);
    check("tie_app", 32'(mif.rw), 32'd1);
    check("tie_addr", 32'(mif.address), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
